la_pipemux: RTL

LA_PIPEMUX -- requirements
Module: la_pipemux

---
 rtl/la_pipemux_pkg.sv | 17 +
 rtl/la_skidbuf.sv | 62 ++++++
 rtl/la_pipemux.sv | 123 ++++++++++++
 3 files changed

// File: rtl/la_pipemux_pkg.sv
// la_pipemux_pkg
//   Shared definitions for the packet-locking pipelined multiplexer.
//   - lock_state_t : lock FSM state encoding
//   - sel_w()      : width of the binary channel select for an N-channel mux
package la_pipemux_pkg;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  // At least one bit so an N=1 instance would still elaborate cleanly.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/la_skidbuf.sv
// la_skidbuf
//   Two-entry output buffer (main register plus skid register) with a
//   registered ready. Full throughput while out_ready=1, output held stable
//   while stalled, strict FIFO order.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_ready = skid slot empty
//   in_data [DW-1:0]      upstream payload
//   out_valid/out_ready   downstream handshake (out_valid = main full)
//   out_data [DW-1:0]     main register contents
module la_skidbuf #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          main_valid;
  logic          skid_valid;
  logic [DW-1:0] main_data;
  logic [DW-1:0] skid_data;
  logic          push;
  logic          pop;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign push      = in_valid & in_ready;
  assign pop       = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Skid full implies main full and no push; a pop refills main from skid.
      if (pop) skid_valid <= 1'b0;
    end else if (push) begin
      if (main_valid && !pop) skid_valid <= 1'b1;
      else                    main_valid <= 1'b1;
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid flags.
  always_ff @(posedge clk) begin
    if (skid_valid) begin
      if (pop) main_data <= skid_data;
    end else if (push) begin
      if (main_valid && !pop) skid_data <= in_data;
      else                    main_data <= in_data;
    end
  end

endmodule

// File: rtl/la_pipemux.sv
// la_pipemux
//   N:1 packet multiplexer. The channel picked by sel is locked for the
//   duration of a packet (until a beat with in_last=1 is accepted); the
//   selected stream is registered through a two-entry skid buffer.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   sel [sel_w(N)-1:0]         binary channel select, used only while unlocked
//   in_valid/in_ready [N-1:0]  per-channel handshake (one-hot or zero ready)
//   in_data [N*W-1:0]          channel i at [i*W +: W]
//   in_last [N-1:0]            per-channel end-of-packet
//   out_valid/out_ready        downstream handshake
//   out_data [W-1:0], out_last selected beat
//   locked                     packet in progress on the locked channel
//
// state       | meaning
// ST_UNLOCKED | between packets; effective select follows sel
// ST_LOCKED   | mid-packet; effective select frozen at lock_sel_q
module la_pipemux
  import la_pipemux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [sel_w(N)-1:0] sel,
  input  logic [N-1:0]        in_valid,
  input  logic [N*W-1:0]      in_data,
  input  logic [N-1:0]        in_last,
  output logic [N-1:0]        in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic                locked
);

  localparam int SW = sel_w(N);

  // PROP is an opaque tag for implementation flows; it changes nothing here.
  if (PROP == "") begin : g_prop_unset
  end

  lock_state_t   state_q, state_d;
  logic [SW-1:0] lock_sel_q, lock_sel_d;
  logic [SW-1:0] eff_sel;
  logic          mux_valid;
  logic [W-1:0]  mux_data;
  logic          mux_last;
  logic          sb_in_valid;
  logic          sb_in_ready;
  logic          accept;
  logic [W:0]    sb_out;

  assign eff_sel = (state_q == ST_LOCKED) ? lock_sel_q : sel;

  // Pure decode: a select of N or more matches no channel, so nothing is
  // offered and every in_ready stays low.
  always_comb begin
    mux_valid = 1'b0;
    mux_data  = '0;
    mux_last  = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (eff_sel == SW'(i)) begin
        mux_valid   = in_valid[i];
        mux_data    = in_data[i*W +: W];
        mux_last    = in_last[i];
        in_ready[i] = sb_in_ready & ~reset;
      end
    end
  end

  assign sb_in_valid = mux_valid & ~reset;
  assign accept      = sb_in_valid & sb_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (accept && !mux_last) begin
          state_d    = ST_LOCKED;
          lock_sel_d = eff_sel;
        end
      end
      ST_LOCKED: begin
        if (accept && mux_last) state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  assign locked = (state_q == ST_LOCKED);

  la_skidbuf #(
    .DW (W + 1)
  ) u_skidbuf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (sb_in_valid),
    .in_ready  (sb_in_ready),
    .in_data   ({mux_last, mux_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (sb_out)
  );

  assign out_data = sb_out[W-1:0];
  assign out_last = sb_out[W];

endmodule
